// File: rtl/uart_frame_accumulator.sv
// UART byte-to-frame accumulator: CR or TERM0/TERM1 terminated, 1-cycle registered outputs, valid/ack hold
// (in_ready low while a frame is held). Define ACC_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_frame_accumulator #(
  parameter int         MAX_BYTES = 128,
  parameter int         TIMEOUT   = 2000,
  parameter logic [7:0] CR_BYTE   = 8'h0D,
  parameter logic [7:0] TERM0     = 8'hBE,
  parameter logic [7:0] TERM1     = 8'hEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             soft_reset,
  input  logic [7:0]                       in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             term_mode,
  output logic [MAX_BYTES*8-1:0]           frame_data,
  output logic [$clog2(MAX_BYTES+1)-1:0]   frame_len,
  output logic                             frame_valid,
  input  logic                             frame_ack,
  output logic                             busy,
  output logic                             err,
  output logic [2:0]                       err_code
);

  localparam int LW = $clog2(MAX_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, TERM2, HOLD} state_t;

  state_t          state_q, state_d;
  logic [7:0]      buf_q [MAX_BYTES];
  logic [7:0]      buf_d [MAX_BYTES];
  logic [LW-1:0]   count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            mode_q, mode_d;
  logic            err_q, err_d;
  logic [2:0]      code_q, code_d;
  logic [7:0]      xor_q, xor_d;
  logic            store, finish, clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      buf_q   <= '{default: '0};
      count_q <= '0;
      timer_q <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      xor_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      timer_q <= timer_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      code_q  <= code_d;
      xor_q   <= xor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    count_d = count_q;
    timer_d = timer_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    code_d  = code_q;
    xor_d   = xor_q;
    store   = 1'b0;
    finish  = 1'b0;
    clear   = 1'b0;

    case (state_q)
      IDLE: begin
        // count_q is always zero here, so the shared store path writes index 0
        if (in_valid && !(term_mode ? (in_data == CR_BYTE) : (in_data == TERM0))) begin
          store   = 1'b1;
          mode_d  = term_mode;
          timer_d = '0;
          state_d = ACCUM;
        end
      end
      ACCUM, TERM2: begin
        if (in_valid) begin
          timer_d = '0;
          if (state_q == TERM2) begin
            if (in_data == TERM1) begin
              finish = 1'b1;
            end else begin
              err_d  = 1'b1;
              code_d = 3'd3;
              clear  = 1'b1;
            end
          end else if (mode_q && in_data == CR_BYTE) begin
            finish = 1'b1;
          end else if (!mode_q && in_data == TERM0) begin
            state_d = TERM2;
          end else if (count_q < LW'(MAX_BYTES)) begin
            store = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = 3'd2;
            clear  = 1'b1;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d  = 1'b1;
          code_d = 3'd1;
          clear  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      HOLD: begin
        if (frame_ack) clear = 1'b1;
      end
      default: clear = 1'b1;
    endcase

    if (store) begin
      for (int i = 0; i < MAX_BYTES; i++)
        if (i == int'(count_q)) buf_d[i] = in_data;
      count_d = count_q + LW'(1);
      xor_d   = xor_q ^ in_data;
    end

    if (finish) begin
`ifdef ACC_CHECKSUM_EN
      // Running XOR over payload plus checksum byte must cancel to zero
      if (count_q == '0 || xor_q != 8'h00) begin
        err_d  = 1'b1;
        code_d = 3'd4;
        clear  = 1'b1;
      end else begin
        for (int i = 0; i < MAX_BYTES; i++)
          if (i == int'(count_q) - 1) buf_d[i] = 8'h00;
        count_d = count_q - LW'(1);
        state_d = HOLD;
      end
`else
      state_d = HOLD;
`endif
    end

    if (clear || soft_reset) begin
      state_d = IDLE;
      buf_d   = '{default: '0};
      count_d = '0;
      timer_d = '0;
      xor_d   = '0;
    end
    if (soft_reset) begin
      err_d  = 1'b0;
      code_d = code_q;
    end
  end

  always_comb begin
    in_ready    = (state_q != HOLD);
    busy        = (state_q == ACCUM) || (state_q == TERM2);
    frame_valid = (state_q == HOLD);
    frame_len   = (state_q == HOLD) ? count_q : '0;
    err         = err_q;
    err_code    = code_q;
    for (int i = 0; i < MAX_BYTES; i++)
      frame_data[8*i +: 8] = buf_q[i];
  end

endmodule

// File: tb/tb_uart_frame_accumulator.sv
// Directed self-checking bench for uart_frame_accumulator (MAX_BYTES=4, TIMEOUT=8).
module tb_uart_frame_accumulator;

  logic        clk = 1'b0;
  logic        reset, soft_reset, in_valid, term_mode, frame_ack;
  logic [7:0]  in_data;
  logic        in_ready, frame_valid, busy, err;
  logic [31:0] frame_data;
  logic [2:0]  frame_len, err_code;
  int          checks = 0;
  int          errors = 0;

  uart_frame_accumulator #(.MAX_BYTES(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .soft_reset(soft_reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .term_mode(term_mode), .frame_data(frame_data), .frame_len(frame_len),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .busy(busy),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Tasks start and end on a negedge; the byte is captured by the posedge in between
  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; soft_reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    term_mode = 1'b1; frame_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (frame_valid !== 1'b0)  begin errors++; $display("FAIL rst_frame_valid got %b exp 0", frame_valid); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (err !== 1'b0)          begin errors++; $display("FAIL rst_err got %b exp 0", err); end
    checks++; if (err_code !== 3'd0)     begin errors++; $display("FAIL rst_err_code got %0d exp 0", err_code); end
    checks++; if (frame_len !== 3'd0)    begin errors++; $display("FAIL rst_frame_len got %0d exp 0", frame_len); end
    checks++; if (frame_data !== 32'h0)  begin errors++; $display("FAIL rst_frame_data got %h exp 0", frame_data); end
  endtask

  task automatic test_cr_frame();
    term_mode = 1'b1;
    send(8'h0D);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cr_idle_discard busy got %b exp 0", busy); end
    send(8'h41);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cr_busy got %b exp 1", busy); end
    send(8'h42); send(8'h43);
`ifdef ACC_CHECKSUM_EN
    send(8'h40);
`endif
    send(8'h0D);
    checks++; if (frame_valid !== 1'b1)       begin errors++; $display("FAIL cr_valid got %b exp 1", frame_valid); end
    checks++; if (frame_len !== 3'd3)         begin errors++; $display("FAIL cr_len got %0d exp 3", frame_len); end
    checks++; if (frame_data !== 32'h00434241) begin errors++; $display("FAIL cr_data got %h exp 00434241", frame_data); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL cr_hold_flags got rdy=%b busy=%b exp 0 0", in_ready, busy); end
    repeat (3) @(negedge clk);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL cr_valid_held got %b exp 1", frame_valid); end
    ack();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL cr_ack_drop got %b exp 0", frame_valid); end
    checks++; if (frame_data !== 32'h0) begin errors++; $display("FAIL cr_ack_clear got %h exp 0", frame_data); end
  endtask

  task automatic test_two_byte();
    term_mode = 1'b0;
    send(8'h01); send(8'h02);
`ifdef ACC_CHECKSUM_EN
    send(8'h03);
`endif
    send(8'hBE);
    checks++; if (busy !== 1'b1 || frame_valid !== 1'b0) begin errors++; $display("FAIL tb_term2 got busy=%b valid=%b exp 1 0", busy, frame_valid); end
    send(8'hEF);
    checks++; if (frame_valid !== 1'b1)        begin errors++; $display("FAIL tb_valid got %b exp 1", frame_valid); end
    checks++; if (frame_len !== 3'd2)          begin errors++; $display("FAIL tb_len got %0d exp 2", frame_len); end
    checks++; if (frame_data !== 32'h00000201) begin errors++; $display("FAIL tb_data got %h exp 00000201", frame_data); end
    ack();
    send(8'h01); send(8'hBE); send(8'h55);
    checks++; if (err !== 1'b1 || err_code !== 3'd3) begin errors++; $display("FAIL badterm got err=%b code=%0d exp 1 3", err, err_code); end
    checks++; if (busy !== 1'b0 || frame_valid !== 1'b0) begin errors++; $display("FAIL badterm_idle got busy=%b valid=%b exp 0 0", busy, frame_valid); end
    @(negedge clk);
    checks++; if (err !== 1'b0 || err_code !== 3'd3) begin errors++; $display("FAIL badterm_pulse got err=%b code=%0d exp 0 3", err, err_code); end
  endtask

  task automatic test_overflow();
    term_mode = 1'b1;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ovf_full got err=%b busy=%b exp 0 1", err, busy); end
    send(8'h05);
    checks++; if (err !== 1'b1 || err_code !== 3'd2) begin errors++; $display("FAIL ovf_err got err=%b code=%0d exp 1 2", err, err_code); end
    checks++; if (frame_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ovf_state got valid=%b busy=%b exp 0 0", frame_valid, busy); end
    checks++; if (frame_data !== 32'h0) begin errors++; $display("FAIL ovf_clear got %h exp 0", frame_data); end
  endtask

  task automatic test_timeout();
    term_mode = 1'b1;
    send(8'h11);
    repeat (7) @(negedge clk);
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_early got err=%b busy=%b exp 0 1", err, busy); end
    send(8'h22);
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_byte_wins got err=%b busy=%b exp 0 1", err, busy); end
    repeat (7) @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_restart got err=%b exp 0", err); end
    @(negedge clk);
    checks++; if (err !== 1'b1 || err_code !== 3'd1) begin errors++; $display("FAIL to_expire got err=%b code=%0d exp 1 1", err, err_code); end
    checks++; if (busy !== 1'b0 || frame_data !== 32'h0) begin errors++; $display("FAIL to_idle got busy=%b data=%h exp 0 0", busy, frame_data); end
  endtask

  task automatic test_hold();
    term_mode = 1'b1;
    send(8'h41); send(8'h42);
`ifdef ACC_CHECKSUM_EN
    send(8'h03);
`endif
    send(8'h0D);
    send(8'h77);
    checks++; if (in_ready !== 1'b0 || frame_valid !== 1'b1) begin errors++; $display("FAIL hold_strobe got rdy=%b valid=%b exp 0 1", in_ready, frame_valid); end
    checks++; if (frame_len !== 3'd2 || frame_data !== 32'h00004241) begin errors++; $display("FAIL hold_frame got len=%0d data=%h exp 2 00004241", frame_len, frame_data); end
    repeat (12) @(negedge clk);
    checks++; if (frame_valid !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL hold_no_timeout got valid=%b err=%b exp 1 0", frame_valid, err); end
    ack();
    checks++; if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got valid=%b rdy=%b exp 0 1", frame_valid, in_ready); end
  endtask

  task automatic test_soft_reset();
    term_mode = 1'b1;
    send(8'h55); send(8'h66);
    soft_reset = 1'b1;
    @(negedge clk);
    soft_reset = 1'b0;
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL srst_idle got busy=%b err=%b exp 0 0", busy, err); end
    checks++; if (err_code !== 3'd1) begin errors++; $display("FAIL srst_code_kept got %0d exp 1", err_code); end
    checks++; if (frame_data !== 32'h0) begin errors++; $display("FAIL srst_clear got %h exp 0", frame_data); end
    send(8'hAA);
`ifdef ACC_CHECKSUM_EN
    send(8'hAA);
`endif
    send(8'h0D);
    checks++; if (frame_len !== 3'd1 || frame_data !== 32'h000000AA) begin errors++; $display("FAIL srst_next got len=%0d data=%h exp 1 000000aa", frame_len, frame_data); end
    ack();
  endtask

  task automatic test_checksum();
    term_mode = 1'b1;
    send(8'h10); send(8'h20); send(8'h30); send(8'h0D);
`ifdef ACC_CHECKSUM_EN
    checks++; if (frame_len !== 3'd2 || frame_data !== 32'h00002010) begin errors++; $display("FAIL cks_ok got len=%0d data=%h exp 2 00002010", frame_len, frame_data); end
`else
    checks++; if (frame_len !== 3'd3 || frame_data !== 32'h00302010) begin errors++; $display("FAIL cks_off got len=%0d data=%h exp 3 00302010", frame_len, frame_data); end
`endif
    ack();
    send(8'h10); send(8'h20); send(8'h31); send(8'h0D);
`ifdef ACC_CHECKSUM_EN
    checks++; if (err !== 1'b1 || err_code !== 3'd4 || frame_valid !== 1'b0) begin errors++; $display("FAIL cks_bad got err=%b code=%0d valid=%b exp 1 4 0", err, err_code, frame_valid); end
`else
    checks++; if (frame_len !== 3'd3 || frame_data !== 32'h00312010 || err !== 1'b0) begin errors++; $display("FAIL cks_off2 got len=%0d data=%h err=%b exp 3 00312010 0", frame_len, frame_data, err); end
    ack();
`endif
  endtask

  task automatic test_async_reset();
    term_mode = 1'b1;
    send(8'h01); send(8'h02);
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || frame_data !== 32'h0 || err_code !== 3'd0) begin errors++; $display("FAIL arst got busy=%b data=%h code=%0d exp 0 0 0", busy, frame_data, err_code); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cr_frame();
    test_two_byte();
    test_overflow();
    test_timeout();
    test_hold();
    test_soft_reset();
    test_checksum();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
